// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_SAMPLE  = 7;
  localparam int unsigned LAST_SAMPLE = 15;
  localparam int unsigned TICK_CNT_W  = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter; reset loads the line's idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_TICKS = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

  logic rx_s;

  uart_state_e           state_q,    state_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0]  shreg_q,    shreg_d;
  logic                  perr_q,     perr_d;
  logic [DATA_BITS-1:0]  data_q,     data_d;
  logic                  done_q,     done_d;
  logic                  ferr_q,     ferr_d;
  logic                  perr_out_q, perr_out_d;
  logic                  busy_q,     busy_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      busy_q     <= busy_d;
    end
  end

  // Frame sequencing; counters only move on oversample ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_CNT_W'(MID_SAMPLE)) begin
            if (!rx_s) begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_CNT_W'(LAST_SAMPLE)) begin
            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_CNT_W'(LAST_SAMPLE)) begin
            perr_d     = (^shreg_q) ^ rx_s ^ 1'(PARITY_ODD);
            tick_cnt_d = '0;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_CNT_W'(STOP_TICKS - 1)) begin
            data_d     = shreg_q;
            ferr_d     = ~rx_s;
            perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_data       = data_q;
  assign o_rx_done    = done_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_out_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames on a plain and a parity receiver.
module tb_uart_rx;

  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned BIT_T    = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b0;
  logic       rx      = 1'b1;
  logic       rx_p    = 1'b1;
  logic [7:0] data,   data_p;
  logic       done,   done_p;
  logic       ferr,   ferr_p;
  logic       perr,   perr_p;
  logic       busy,   busy_p;

  uart_rx #(
    .DATA_BITS (8), .STOP_TICKS (16), .PARITY_EN (0), .PARITY_ODD (0)
  ) dut (
    .i_clk (clk), .i_reset (rst), .i_tick (tick), .i_rx (rx),
    .o_data (data), .o_rx_done (done), .o_frame_err (ferr),
    .o_parity_err (perr), .o_busy (busy)
  );

  uart_rx #(
    .DATA_BITS (8), .STOP_TICKS (16), .PARITY_EN (1), .PARITY_ODD (0)
  ) dut_p (
    .i_clk (clk), .i_reset (rst), .i_tick (tick), .i_rx (rx_p),
    .o_data (data_p), .o_rx_done (done_p), .o_frame_err (ferr_p),
    .o_parity_err (perr_p), .o_busy (busy_p)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clock wide every TICK_DIV clocks.
  int unsigned div_cnt = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt <= 0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      tick    <= 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0]  d;
    logic        fe;
    logic        pe;
    logic [31:0] at;
  } rec_t;

  rec_t q[$];
  rec_t qp[$];
  int   multi = 0;
  logic done_prev = 1'b0, donep_prev = 1'b0;

  // Record every strobe and flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (done === 1'b1) q.push_back('{data, ferr, perr, cyc});
    if (done_p === 1'b1) qp.push_back('{data_p, ferr_p, perr_p, cyc});
    if (done === 1'b1 && done_prev === 1'b1) multi++;
    if (done_p === 1'b1 && donep_prev === 1'b1) multi++;
    done_prev  = done;
    donep_prev = done_p;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait for n clock edges at which the DUT saw i_tick high, then step off the edge.
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic line(input bit par, input logic v);
    if (par) rx_p = v;
    else     rx   = v;
  endtask

  // Transmit one frame; a bad stop bit is held low long enough to be sampled,
  // followed by idle so the receiver settles before the next frame.
  task automatic send(input bit par, input logic [7:0] d, input logic pbit, input bit stop_ok);
    line(par, 1'b0);
    ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      line(par, d[i]);
      ticks(BIT_T);
    end
    if (par) begin
      line(par, pbit);
      ticks(BIT_T);
    end
    if (stop_ok) begin
      line(par, 1'b1);
      ticks(BIT_T);
    end else begin
      line(par, 1'b0);
      ticks(12);
      line(par, 1'b1);
      ticks(24);
    end
  endtask

  // Reference: what a frame should report, from its content alone.
  function automatic logic model_perr(input logic [7:0] d, input logic pbit);
    return ((($countones(d) + int'(pbit)) % 2) != 0);
  endfunction

  task automatic expect_rec(input bit par, input string tag, input logic [7:0] d,
                            input logic fe, input logic pe, output int unsigned at);
    rec_t r;
    int   waited = 0;
    at = 0;
    while (((par ? qp.size() : q.size()) == 0) && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check({tag, "_strobe"}, 32'((par ? qp.size() : q.size()) > 0), 32'd1);
    if ((par ? qp.size() : q.size()) > 0) begin
      if (par) r = qp.pop_front();
      else     r = q.pop_front();
      check({tag, "_data"}, 32'(r.d), 32'(d));
      check({tag, "_ferr"}, 32'(r.fe), 32'(fe));
      check({tag, "_perr"}, 32'(r.pe), 32'(pe));
      at = r.at;
    end
  endtask

  initial begin
    int unsigned t0, t1;
    logic [7:0]  d;
    logic        pb;
    bit          ok;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data", 32'(data), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_perr", 32'(perr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    ticks(3);

    // Clean frame 0xA5
    send(1'b0, 8'hA5, 1'b0, 1'b1);
    expect_rec(1'b0, "a5", 8'hA5, 1'b0, 1'b0, t0);
    check("a5_idle_busy", 32'(busy), 32'h0);
    check("a5_single", 32'(q.size()), 32'd0);

    // Short low glitch is rejected at mid start bit
    rx = 1'b0;
    ticks(4);
    check("glitch_busy_mid", 32'(busy), 32'h1);
    rx = 1'b1;
    ticks(BIT_T);
    check("glitch_busy_after", 32'(busy), 32'h0);
    check("glitch_no_strobe", 32'(q.size()), 32'd0);
    check("glitch_data_hold", 32'(data), 32'hA5);

    // Framing error, then a good frame clears it
    send(1'b0, 8'h3C, 1'b0, 1'b0);
    expect_rec(1'b0, "ferr3c", 8'h3C, 1'b1, 1'b0, t0);
    check("ferr3c_flag_hold", 32'(ferr), 32'h1);
    check("ferr3c_single", 32'(q.size()), 32'd0);
    send(1'b0, 8'h11, 1'b0, 1'b1);
    expect_rec(1'b0, "good11", 8'h11, 1'b0, 1'b0, t0);
    check("good11_ferr_clear", 32'(ferr), 32'h0);

    // Back-to-back frames: strobes exactly one frame (160 ticks) apart
    send(1'b0, 8'h00, 1'b0, 1'b1);
    send(1'b0, 8'hFF, 1'b0, 1'b1);
    expect_rec(1'b0, "b2b00", 8'h00, 1'b0, 1'b0, t0);
    expect_rec(1'b0, "b2bff", 8'hFF, 1'b0, 1'b0, t1);
    check("b2b_spacing", t1 - t0, 32'(10 * BIT_T * TICK_DIV));

    // Reset in the middle of data bit 4 abandons the frame
    rx = 1'b0;
    ticks(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      ticks(BIT_T);
    end
    rx = 1'b1;
    ticks(8);
    check("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data_clr", 32'(data), 32'h0);
    ticks(40);
    check("abort_no_strobe", 32'(q.size()), 32'd0);
    send(1'b0, 8'h5A, 1'b0, 1'b1);
    expect_rec(1'b0, "after_abort", 8'h5A, 1'b0, 1'b0, t0);

    // Random frames against the model, some with a bad stop bit
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send(1'b0, d, 1'b0, ok);
      expect_rec(1'b0, $sformatf("rnd%0d", i), d, 1'(!ok), 1'b0, t0);
    end

    // Even parity receiver
    send(1'b1, 8'h07, 1'b1, 1'b1);
    expect_rec(1'b1, "par07_good", 8'h07, 1'b0, 1'b0, t0);
    send(1'b1, 8'h07, 1'b0, 1'b1);
    expect_rec(1'b1, "par07_bad", 8'h07, 1'b0, 1'b1, t0);
    check("par07_flag_hold", 32'(perr_p), 32'h1);
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      ok = ($urandom_range(3) != 0);
      send(1'b1, d, pb, ok);
      expect_rec(1'b1, $sformatf("prnd%0d", i), d, 1'(!ok), model_perr(d, pb), t0);
    end

    ticks(BIT_T);
    check("end_no_extra", 32'(q.size()), 32'd0);
    check("end_no_extra_p", 32'(qp.size()), 32'd0);
    check("done_one_cycle", 32'(multi), 32'd0);
    check("end_busy", 32'(busy), 32'h0);
    check("end_busy_p", 32'(busy_p), 32'h0);
    check("plain_perr_zero", 32'(perr), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
